// File: rtl/adc_fir_scheduler.sv
// Round-robin scheduler sharing one multi-channel FIR core between N_CH ADC front ends.
// Optional sticky overrun flags are built when ADC_SCHED_OVERRUN_EN is defined.
module adc_fir_scheduler #(
   parameter int N_CH = 8,
   parameter int DW   = 17,
   parameter int OW   = 18
) (
   input  logic                    processing_clock,
   input  logic                    reset,
   input  logic                    resync,
   input  logic [N_CH-1:0]         sample_valid,
   input  logic [N_CH*DW-1:0]      sample_data,
   input  logic                    fir_rfd,
   input  logic                    fir_rdy,
   input  logic [OW-1:0]           fir_dout,
   output logic                    fir_sclr,
   output logic                    fir_nd,
   output logic [DW-1:0]           fir_din,
   output logic [$clog2(N_CH)-1:0] fir_chan,
   output logic [N_CH*32-1:0]      ch_data,
   output logic [N_CH-1:0]         ch_update,
   output logic [N_CH-1:0]         overrun,
   input  logic                    overrun_clear,
   output logic [1:0]              fsm_state
);

   localparam int CW = $clog2(N_CH);
   localparam logic [1:0] ST_CLR   = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

   // Handshake: a sample is handed to the FIR when the scheduler is IDLE, the
   // channel at next_ch is pending and fir_rfd is high; fir_nd pulses the cycle after.
   logic [1:0]      state;
   logic            clr_cnt;
   logic [CW-1:0]   next_ch;
   logic [CW-1:0]   out_ch;
   logic [DW-1:0]   hold [N_CH];
   logic [N_CH-1:0] pending;
   logic [31:0]     ch_reg [N_CH];
   logic            grant;
   logic [N_CH-1:0] grant_vec;
   logic            accept;
   logic [31:0]     ch_word;

   assign grant   = (state == ST_IDLE) && pending[next_ch] && fir_rfd;
   assign accept  = (state != ST_CLR) && !resync;
   assign ch_word = 32'(fir_dout) << (32 - OW);

   always_comb begin
      grant_vec = '0;
      if (grant) grant_vec[next_ch] = 1'b1;
   end

   assign fir_sclr  = (state == ST_CLR);
   assign fir_nd    = (state == ST_ISSUE);
   assign fsm_state = state;

   always_ff @(posedge processing_clock) begin
      if (reset) begin
         state    <= ST_CLR;
         clr_cnt  <= 1'b0;
         next_ch  <= '0;
         fir_din  <= '0;
         fir_chan <= '0;
      end else if (resync) begin
         state   <= ST_CLR;
         clr_cnt <= 1'b0;
         next_ch <= '0;
      end else begin
         case (state)
            ST_CLR: begin
               if (clr_cnt) state <= ST_IDLE;
               clr_cnt <= 1'b1;
            end
            ST_IDLE: begin
               if (grant) begin
                  fir_din  <= hold[next_ch];
                  fir_chan <= next_ch;
                  next_ch  <= (next_ch == CW'(N_CH - 1)) ? '0 : next_ch + 1'b1;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_IDLE;
            default:  state <= ST_CLR;
         endcase
      end
   end

   // A strobe coinciding with its own grant re-arms pending with the new sample.
   always_ff @(posedge processing_clock) begin
      for (int i = 0; i < N_CH; i++) begin
         if (reset) begin
            hold[i]    <= '0;
            pending[i] <= 1'b0;
         end else if (!accept) begin
            pending[i] <= 1'b0;
         end else if (sample_valid[i]) begin
            hold[i]    <= sample_data[i*DW +: DW];
            pending[i] <= 1'b1;
         end else if (grant_vec[i]) begin
            pending[i] <= 1'b0;
         end
      end
   end

`ifdef ADC_SCHED_OVERRUN_EN
   logic [N_CH-1:0] ovr_set;
   assign ovr_set = accept ? (sample_valid & pending & ~grant_vec) : '0;

   always_ff @(posedge processing_clock) begin
      for (int i = 0; i < N_CH; i++) begin
         if (reset)                overrun[i] <= 1'b0;
         else if (ovr_set[i])      overrun[i] <= 1'b1;
         else if (overrun_clear)   overrun[i] <= 1'b0;
      end
   end
`else
   logic unused_overrun_clear;
   assign unused_overrun_clear = overrun_clear;
   assign overrun = '0;
`endif

   always_ff @(posedge processing_clock) begin
      if (reset) begin
         out_ch    <= '0;
         ch_update <= '0;
         for (int i = 0; i < N_CH; i++) ch_reg[i] <= '0;
      end else begin
         ch_update <= '0;
         if (resync) begin
            out_ch <= '0;
         end else if ((state != ST_CLR) && fir_rdy) begin
            ch_reg[out_ch]    <= ch_word;
            ch_update[out_ch] <= 1'b1;
            out_ch            <= (out_ch == CW'(N_CH - 1)) ? '0 : out_ch + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch_data
      assign ch_data[g*32 +: 32] = ch_reg[g];
   end

endmodule

// File: tb/tb_adc_fir_scheduler.sv
// Directed scoreboard bench for adc_fir_scheduler: issue and result queues checked by a monitor.
module tb_adc_fir_scheduler;

   localparam int N_CH = 8;
   localparam int DW   = 17;
   localparam int OW   = 18;
   localparam int CW   = 3;
`ifdef ADC_SCHED_OVERRUN_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset, resync, fir_rfd, fir_rdy, overrun_clear;
   logic [N_CH-1:0]      sample_valid;
   logic [N_CH*DW-1:0]   sample_data;
   logic [OW-1:0]        fir_dout;
   logic                 fir_sclr, fir_nd;
   logic [DW-1:0]        fir_din;
   logic [CW-1:0]        fir_chan;
   logic [N_CH*32-1:0]   ch_data;
   logic [N_CH-1:0]      ch_update, overrun;
   logic [1:0]           fsm_state;

   int checks = 0;
   int failures = 0;
   int nd_count = 0;
   int cyc = 0;
   int last_cyc = 0;
   bit have_last = 1'b0;
   bit gap_check = 1'b0;

   logic [CW+DW-1:0] exp_iss_q[$];
   logic [CW+31:0]   exp_out_q[$];
   logic [31:0]      exp_ch [N_CH];
   logic [CW+DW-1:0] e_iss;
   logic [CW+31:0]   e_out;

   adc_fir_scheduler #(.N_CH(N_CH), .DW(DW), .OW(OW)) dut (
      .processing_clock(clk),
      .reset(reset),
      .resync(resync),
      .sample_valid(sample_valid),
      .sample_data(sample_data),
      .fir_rfd(fir_rfd),
      .fir_rdy(fir_rdy),
      .fir_dout(fir_dout),
      .fir_sclr(fir_sclr),
      .fir_nd(fir_nd),
      .fir_din(fir_din),
      .fir_chan(fir_chan),
      .ch_data(ch_data),
      .ch_update(ch_update),
      .overrun(overrun),
      .overrun_clear(overrun_clear),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // monitor: pops and compares whenever the DUT presents an issue or a result
   always @(negedge clk) begin
      if (!reset) begin
         if (fir_nd) begin
            nd_count++;
            if (gap_check && have_last) begin
               checks++;
               if (cyc - last_cyc != 2) begin
                  failures++;
                  $display("FAIL issue_gap got=%0d cycles expected=2", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            have_last = 1'b1;
            checks++;
            if (exp_iss_q.size() == 0) begin
               failures++;
               $display("FAIL issue_unexpected chan=%0d din=%h expected none", fir_chan, fir_din);
            end else begin
               e_iss = exp_iss_q.pop_front();
               if ({fir_chan, fir_din} !== e_iss) begin
                  failures++;
                  $display("FAIL issue chan=%0d din=%h expected chan=%0d din=%h",
                           fir_chan, fir_din, e_iss[CW+DW-1:DW], e_iss[DW-1:0]);
               end
            end
         end
         if (ch_update != '0) begin
            checks++;
            if (exp_out_q.size() == 0) begin
               failures++;
               $display("FAIL update_unexpected ch_update=%b expected none", ch_update);
            end else begin
               e_out = exp_out_q.pop_front();
               if (ch_update !== (N_CH'(1) << e_out[CW+31:32]) ||
                   ch_data[e_out[CW+31:32]*32 +: 32] !== e_out[31:0]) begin
                  failures++;
                  $display("FAIL update ch_update=%b data=%h expected ch=%0d data=%h",
                           ch_update, ch_data[e_out[CW+31:32]*32 +: 32],
                           e_out[CW+31:32], e_out[31:0]);
               end
            end
         end
      end
   end

   // driver tasks
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_iss(input int ch, input logic [DW-1:0] val);
      exp_iss_q.push_back({CW'(ch), val});
   endtask

   task automatic strobe_mask(input logic [N_CH-1:0] mask, input logic [DW-1:0] base);
      for (int i = 0; i < N_CH; i++) sample_data[i*DW +: DW] = base + DW'(i);
      sample_valid = mask;
      tick();
      sample_valid = '0;
   endtask

   task automatic strobe_one(input int ch, input logic [DW-1:0] val);
      sample_data = '0;
      sample_data[ch*DW +: DW] = val;
      sample_valid = N_CH'(1) << ch;
      tick();
      sample_valid = '0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_iss_q.size() != 0 || exp_out_q.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check(name, 64'(exp_iss_q.size() + exp_out_q.size()), 64'd0);
   endtask

   task automatic check_sclr_seq(input string name);
      @(negedge clk); check({name, "_sclr0"}, 64'(fir_sclr), 64'd1);
      tick();
      @(negedge clk); check({name, "_sclr1"}, 64'(fir_sclr), 64'd1);
      tick();
      @(negedge clk); check({name, "_sclr2"}, 64'(fir_sclr), 64'd0);
      check({name, "_state"}, 64'(fsm_state), 64'd1);
      tick();
   endtask

   int base_nd;

   initial begin
      reset = 1'b1; resync = 1'b0; sample_valid = '0; sample_data = '0;
      fir_rfd = 1'b1; fir_rdy = 1'b0; fir_dout = '0; overrun_clear = 1'b0;
      for (int i = 0; i < N_CH; i++) exp_ch[i] = 32'h0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_sclr", 64'(fir_sclr), 64'd1);
      check("rst_nd", 64'(fir_nd), 64'd0);
      check("rst_din", 64'(fir_din), 64'd0);
      check("rst_chan", 64'(fir_chan), 64'd0);
      check("rst_ch_data_zero", 64'(ch_data == '0), 64'd1);
      check("rst_update", 64'(ch_update), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      tick();
      reset = 1'b0;
      check_sclr_seq("rst_rel");

      // all channels once, issued in order every 2nd cycle
      have_last = 1'b0;
      gap_check = 1'b1;
      for (int i = 0; i < N_CH; i++) push_iss(i, 17'h00010 + DW'(i));
      strobe_mask(8'hFF, 17'h00010);
      wait_drain("drain_all");
      gap_check = 1'b0;

      // channel 0 missing stalls everyone
      base_nd = nd_count;
      strobe_mask(8'hFE, 17'h00020);
      repeat (20) tick();
      check("stall_no_issue", 64'(nd_count), 64'(base_nd));
      for (int i = 0; i < N_CH; i++) push_iss(i, 17'h00020 + DW'(i));
      strobe_one(0, 17'h00020);
      wait_drain("drain_stall");

      // overwrite before grant, overrun flag, set-beats-clear
      strobe_one(3, 17'd5);
      strobe_one(3, 17'd9);
      check("ovr_set", 64'(overrun), OVR ? 64'h08 : 64'h00);
      push_iss(0, 17'd1); push_iss(1, 17'd2); push_iss(2, 17'd3); push_iss(3, 17'd9);
      strobe_mask(8'h07, 17'd1);
      strobe_one(5, 17'h00021);
      overrun_clear = 1'b1;
      strobe_one(5, 17'h00025);
      overrun_clear = 1'b0;
      check("ovr_set_wins", 64'(overrun), OVR ? 64'h20 : 64'h00);
      overrun_clear = 1'b1;
      tick();
      overrun_clear = 1'b0;
      check("ovr_clear", 64'(overrun), 64'h00);
      push_iss(4, 17'h00044); push_iss(5, 17'h00025);
      push_iss(6, 17'h00046); push_iss(7, 17'h00047);
      strobe_mask(8'hD0, 17'h00040);
      wait_drain("drain_ovr");

      // strobe of channel 2 in its own grant cycle
      push_iss(0, 17'h00030); push_iss(1, 17'h00031);
      strobe_mask(8'h03, 17'h00030);
      wait_drain("drain_pre_grant");
      fir_rfd = 1'b0;
      strobe_one(2, 17'd4);
      tick();
      push_iss(2, 17'd4);
      sample_data = '0;
      sample_data[2*DW +: DW] = 17'd6;
      sample_valid = 8'h04;
      fir_rfd = 1'b1;
      tick();
      sample_valid = '0;
      check("ovr_grant_same", 64'(overrun), 64'h00);
      for (int i = 3; i < N_CH; i++) push_iss(i, 17'h00050 + DW'(i));
      push_iss(0, 17'h00050); push_iss(1, 17'h00051); push_iss(2, 17'd6);
      strobe_mask(8'hFB, 17'h00050);
      wait_drain("drain_grant_same");

      // result steering with wrap
      for (int k = 0; k < 9; k++) begin
         fir_dout = (k < 8) ? 18'h3FFFF : 18'h00001;
         fir_rdy = 1'b1;
         exp_ch[k % N_CH] = (k < 8) ? 32'hFFFFC000 : 32'h00004000;
         exp_out_q.push_back({CW'(k % N_CH), exp_ch[k % N_CH]});
         tick();
      end
      fir_rdy = 1'b0;
      wait_drain("drain_out");
      for (int i = 0; i < N_CH; i++) check($sformatf("ch_data_%0d", i), 64'(ch_data[i*32 +: 32]), 64'(exp_ch[i]));

      // resync with next_ch=5 and channels 5,6 pending
      push_iss(3, 17'h00063); push_iss(4, 17'h00064);
      strobe_mask(8'h18, 17'h00060);
      wait_drain("drain_pre_resync");
      fir_rfd = 1'b0;
      strobe_mask(8'h60, 17'h00060);
      resync = 1'b1;
      tick();
      resync = 1'b0;
      sample_data = '0;
      sample_data[0 +: DW] = 17'h00011;
      sample_valid = 8'h01;
      fir_rdy = 1'b1;
      fir_dout = 18'h2AAAA;
      @(negedge clk); check("resync_sclr0", 64'(fir_sclr), 64'd1);
      tick();
      sample_valid = '0;
      fir_rdy = 1'b0;
      @(negedge clk); check("resync_sclr1", 64'(fir_sclr), 64'd1);
      tick();
      @(negedge clk); check("resync_sclr2", 64'(fir_sclr), 64'd0);
      tick();
      fir_rfd = 1'b1;
      base_nd = nd_count;
      repeat (10) tick();
      check("resync_no_issue", 64'(nd_count), 64'(base_nd));
      for (int i = 0; i < N_CH; i++) check($sformatf("resync_keep_%0d", i), 64'(ch_data[i*32 +: 32]), 64'(exp_ch[i]));
      push_iss(0, 17'h00070); push_iss(1, 17'h00071);
      strobe_mask(8'h03, 17'h00070);
      fir_dout = 18'h12345;
      fir_rdy = 1'b1;
      exp_ch[0] = 32'h48D14000;
      exp_out_q.push_back({CW'(0), exp_ch[0]});
      tick();
      fir_rdy = 1'b0;
      wait_drain("drain_post_resync");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
